// File: rtl/reset_seq.sv
// reset_seq: synchronizes reset_n and the cartridge /RST pin, then releases NUM_STAGES
// reset domains one by one. Optional low-pulse filter: RESET_SEQ_GLITCH_FILTER_EN.
//
// state | meaning
// HOLD  | power-on; waiting for synchronized reset_n release
// GAP   | counting STAGE_GAP cycles, then releasing stage idx
// RUN   | all stages released, outputs stable
// SOFT  | cartridge reset seen; waiting SOFT_MIN quiet cycles
module reset_seq #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_GAP  = 16,
  parameter int SOFT_MIN   = 64,
  parameter int FILT_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  gb_rst_n,
  output logic [NUM_STAGES-1:0] rst_n_stage,
  output logic                  seq_done,
  output logic                  busy
);

  localparam int MAX_GS  = (STAGE_GAP > SOFT_MIN) ? STAGE_GAP : SOFT_MIN;
  localparam int MAX_ALL = (MAX_GS > FILT_LEN) ? MAX_GS : FILT_LEN;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0]         GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]         SOFT_LAST = CW'(SOFT_MIN - 1);
  localparam logic [CW-1:0]         CNT_MAX   = '1;
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  typedef enum logic [1:0] {HOLD, GAP, RUN, SOFT} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [NUM_STAGES-1:0]   stage_nxt;
  logic                    done_nxt;
  logic [1:0]              r_sync, g_sync;
  logic                    gb_req;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      g_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
      g_sync <= {g_sync[0], gb_rst_n};
    end
  end

`ifdef RESET_SEQ_GLITCH_FILTER_EN
  localparam logic [CW-1:0] FILT_C = CW'(FILT_LEN);
  logic [CW-1:0] low_run;

  // Counts consecutive synced-low samples; saturating so a held-low pin keeps the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              low_run <= '0;
    else if (g_sync[1])        low_run <= '0;
    else if (low_run != FILT_C) low_run <= low_run + CW'(1);
  end

  assign gb_req = (low_run == FILT_C);
`else
  assign gb_req = ~g_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HOLD;
      idx         <= '0;
      cnt         <= '0;
      rst_n_stage <= '0;
      seq_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      rst_n_stage <= stage_nxt;
      seq_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    stage_nxt = rst_n_stage;
    done_nxt  = seq_done;
    case (state)
      HOLD: begin
        // Cartridge requests are ignored until the power-on sequence has started.
        if (r_sync[1]) begin
          state_nxt = GAP;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      GAP, RUN: begin
        if (gb_req) begin
          state_nxt = SOFT;
          stage_nxt = '0;
          done_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (state == GAP) begin
          if (cnt == GAP_LAST) begin
            cnt_nxt   = '0;
            stage_nxt = rst_n_stage | (STAGE_ONE << idx);
            if (idx == IDX_LAST) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
      end
      SOFT: begin
        if (gb_req) begin
          cnt_nxt = '0;
        end else if (cnt == SOFT_LAST) begin
          state_nxt = GAP;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign busy = (state != RUN);

endmodule
